// File: rtl/serial_sub4.sv
// Bit-serial 4-bit subtractor: computes (A - B - BI) one bit per cycle, LSB first,
// and presents the registered difference and borrow-out with a one-cycle DONE pulse.
module serial_sub4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       START,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       BI,
  output logic [3:0] DIFF,
  output logic       BO,
  output logic       BUSY,
  output logic       DONE
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  state_t     state_q;
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic [3:0] res_q;
  logic [3:0] diff_q;
  logic [1:0] cnt_q;
  logic       br_q;
  logic       bo_q;
  logic       busy_q;
  logic       done_q;

  logic       d_bit_d;
  logic       br_d;
  logic [3:0] res_d;

  // Full-subtractor step on the current LSBs of the operand shift registers.
  always_comb begin
    d_bit_d = a_q[0] ^ b_q[0] ^ br_q;
    br_d    = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    res_d   = {d_bit_d, res_q[3:1]};
  end

  // Control FSM with the datapath registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= 4'd0;
      b_q     <= 4'd0;
      res_q   <= 4'd0;
      diff_q  <= 4'd0;
      cnt_q   <= 2'd0;
      br_q    <= 1'b0;
      bo_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (START) begin
            a_q     <= A;
            b_q     <= B;
            br_q    <= BI;
            cnt_q   <= 2'd0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          a_q   <= {1'b0, a_q[3:1]};
          b_q   <= {1'b0, b_q[3:1]};
          br_q  <= br_d;
          res_q <= res_d;
          cnt_q <= cnt_q + 2'd1;
          // The last step publishes straight from the step logic so DIFF/BO change only here.
          if (cnt_q == 2'd3) begin
            diff_q  <= res_d;
            bo_q    <= br_d;
            done_q  <= 1'b1;
            state_q <= FIN;
          end
        end
        FIN: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign DIFF = diff_q;
  assign BO   = bo_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_serial_sub4.sv
// Self-checking bench for serial_sub4: an arithmetic reference with a fixed-latency
// timeline is compared on every cycle, plus hand-computed directed expectations.
module tb_serial_sub4;

  logic       clk;
  logic       rst;
  logic       START;
  logic [3:0] A;
  logic [3:0] B;
  logic       BI;
  logic [3:0] DIFF;
  logic       BO;
  logic       BUSY;
  logic       DONE;

  int errors = 0;
  int checks = 0;

  serial_sub4 dut (
    .clk  (clk),
    .rst  (rst),
    .START(START),
    .A    (A),
    .B    (B),
    .BI   (BI),
    .DIFF (DIFF),
    .BO   (BO),
    .BUSY (BUSY),
    .DONE (DONE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] ref_sub(input logic [3:0] a, input logic [3:0] b, input logic bi);
    logic [4:0] r;
    r = {1'b0, a} - {1'b0, b} - {4'd0, bi};
    return r;
  endfunction

  task automatic check(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference timeline: t counts cycles since acceptance, 0 means idle.
  int         t;
  logic [4:0] m_pend;
  logic [3:0] m_diff;
  logic       m_bo;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      t      <= 0;
      m_diff <= 4'd0;
      m_bo   <= 1'b0;
      m_pend <= 5'd0;
    end else if (t == 0) begin
      if (START) begin
        t      <= 1;
        m_pend <= ref_sub(A, B, BI);
      end
    end else if (t == 5) begin
      t <= 0;
    end else begin
      t <= t + 1;
      if (t == 4) begin
        m_bo   <= m_pend[4];
        m_diff <= m_pend[3:0];
      end
    end
  end

  bit chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_DONE", int'(DONE), int'(t == 5));
      check("cyc_BUSY", int'(BUSY), int'(t != 0));
      check("cyc_DIFF", int'(DIFF), int'(m_diff));
      check("cyc_BO",   int'(BO),   int'(m_bo));
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (BUSY && n < 12) begin
      @(negedge clk);
      n++;
    end
    if (BUSY) check("idle_timeout", 1, 0);
  endtask

  task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic bi,
                       input logic [3:0] ed, input logic eb, input string nm, input bit pin_lat);
    int i;
    bit seen;
    @(posedge clk); #2;
    A = a; B = b; BI = bi; START = 1'b1;
    @(posedge clk); #2;
    START = 1'b0;
    A = 4'($urandom); B = 4'($urandom); BI = 1'($urandom);
    seen = 1'b0;
    for (i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (DONE) begin
        seen = 1'b1;
        break;
      end
    end
    check({nm, "_done_seen"}, int'(seen), 1);
    if (seen) begin
      if (pin_lat) check({nm, "_latency"}, i, 5);
      check({nm, "_DIFF"}, int'(DIFF), int'(ed));
      check({nm, "_BO"}, int'(BO), int'(eb));
    end
    wait_idle();
  endtask

  initial begin
    int dn;
    int last_i;
    bit first_ok;
    logic [4:0] r;
    rst = 1'b1; START = 1'b0; A = 4'd0; B = 4'd0; BI = 1'b0;
    #1;
    check("rst_DIFF", int'(DIFF), 0);
    check("rst_BO",   int'(BO),   0);
    check("rst_BUSY", int'(BUSY), 0);
    check("rst_DONE", int'(DONE), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    do_op(4'h0, 4'h0, 1'b0, 4'h0, 1'b0, "zero", 1'b1);
    do_op(4'h7, 4'h4, 1'b0, 4'h3, 1'b0, "7m4", 1'b1);
    do_op(4'h0, 4'h1, 1'b0, 4'hF, 1'b1, "0m1", 1'b1);
    do_op(4'hF, 4'hF, 1'b1, 4'hF, 1'b1, "FmFm1", 1'b0);
    do_op(4'h5, 4'hA, 1'b1, 4'hA, 1'b1, "5mAm1", 1'b0);

    // START held high; operands changed once the first operation is in flight.
    @(posedge clk); #2;
    A = 4'h9; B = 4'h2; BI = 1'b0; START = 1'b1;
    @(posedge clk); #2;
    A = 4'h1; B = 4'h1;
    dn = 0; last_i = 0; first_ok = 1'b0;
    for (int i = 1; i <= 26; i++) begin
      @(negedge clk);
      if (DONE) begin
        dn++;
        if (dn == 1) begin
          check("held_first_at", i, 5);
          check("held_first_DIFF", int'(DIFF), 7);
          check("held_first_BO", int'(BO), 0);
        end else begin
          check("held_spacing", i - last_i, 6);
          check("held_next_DIFF", int'(DIFF), 0);
        end
        last_i = i;
      end
    end
    check("held_done_count", dn, 4);
    START = 1'b0;
    wait_idle();

    // Reset in the middle of an operation, after a nonzero result is on the outputs.
    do_op(4'h0, 4'h1, 1'b0, 4'hF, 1'b1, "pre_rst", 1'b0);
    @(posedge clk); #2;
    A = 4'h8; B = 4'h3; BI = 1'b0; START = 1'b1;
    @(posedge clk); #2;
    START = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("midrst_DIFF", int'(DIFF), 0);
    check("midrst_BO",   int'(BO),   0);
    check("midrst_BUSY", int'(BUSY), 0);
    check("midrst_DONE", int'(DONE), 0);
    @(posedge clk); #2;
    rst = 1'b0;
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (DONE) dn++;
    end
    check("midrst_no_done", dn, 0);
    do_op(4'h8, 4'h3, 1'b0, 4'h5, 1'b0, "post_rst", 1'b1);

    // Exhaustive sweep.
    for (int k = 0; k < 512; k++) begin
      r = ref_sub(4'(k >> 5), 4'(k >> 1), 1'(k));
      do_op(4'(k >> 5), 4'(k >> 1), 1'(k), r[3:0], r[4], "sweep", 1'b0);
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
